// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/full-subtracter cell iterated LSB-first over WIDTH bits.
// Optional signed-overflow flag enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_acc;
  logic             r_mode;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_s;
  logic             w_c_nxt;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_shift;

  always_comb begin
    w_x      = r_sa[0];
    w_y      = r_sb[0];
    w_s      = w_x ^ w_y ^ r_c;
    w_c_nxt  = r_mode ? ((~w_x & w_y) | (~w_x & r_c) | (w_y & r_c))
                      : (( w_x & w_y) | ( w_x & r_c) | (w_y & r_c));
    w_last   = (r_cnt == CW'(WIDTH - 1));
    w_accept = start && (r_state != S_RUN);
    // Accumulator holds WIDTH-1 bits; the sum bit of the final cycle completes the result.
    w_shift  = {w_s, r_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_acc  <= '0;
      r_mode <= 1'b0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (w_accept) begin
      r_sa   <= a;
      r_sb   <= b;
      r_mode <= mode;
      r_c    <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_acc <= w_shift[WIDTH-1:1];
      r_c   <= w_c_nxt;
      if (w_last) begin
        result <= w_shift;
        cout   <= w_c_nxt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;

  // On the last bit r_c is the carry/borrow into the MSB, w_c_nxt the one leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last)   r_ovf <= r_c ^ w_c_nxt;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: WIDTH=8 directed cases plus an exhaustive WIDTH=3 sweep.
module tb_serial_addsub;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        o;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       start8, mode8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, res8;
  logic       start3, mode3, busy3, done3, cout3, ovf3;
  logic [2:0] a3, b3, res3;

  exp_t q8[$];
  exp_t q3[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] b2b_ops [4];

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(res3), .cout(cout3), .ovf(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input bit m, input logic [63:0] x, input logic [63:0] y);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] full;
    logic        sx, sy, sr;
    mask = (64'd1 << w) - 64'd1;
    if (!m) begin
      full = x + y;
      e.r  = full & mask;
      e.c  = full[w];
    end else begin
      e.r = (x - y) & mask;
      e.c = (x < y);
    end
    sx = x[w-1];
    sy = y[w-1];
    sr = e.r[w-1];
`ifdef SERIAL_ADDSUB_OVF_EN
    e.o = m ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
`else
    e.o = 1'b0;
    if (sx ^ sy ^ sr) e.o = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) check("done8_spurious", 1, 0);
      else begin
        e = q8.pop_front();
        check("res8", res8, e.r);
        check("cout8", cout8, e.c);
        check("ovf8", ovf8, e.o);
        check("busy_done8", busy8, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done3) begin
      if (q3.size() == 0) check("done3_spurious", 1, 0);
      else begin
        e = q3.pop_front();
        check("res3", res3, e.r);
        check("cout3", cout3, e.c);
        check("ovf3", ovf3, e.o);
      end
    end
  end

  task automatic run8(input bit m, input logic [7:0] x, input logic [7:0] y);
    int lat;
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    q8.push_back(model(8, m, 64'(x), 64'(y)));
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat8", lat, 8);
  endtask

  task automatic run3(input bit m, input logic [2:0] x, input logic [2:0] y);
    int lat;
    @(negedge clk);
    start3 = 1'b1; mode3 = m; a3 = x; b3 = y;
    q3.push_back(model(3, m, 64'(x), 64'(y)));
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat3", lat, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, cnt;
    b2b_ops[0] = {1'b1, 8'h33, 8'h44};
    b2b_ops[1] = {1'b0, 8'hC8, 8'h64};
    b2b_ops[2] = {1'b1, 8'h01, 8'h02};
    b2b_ops[3] = {1'b0, 8'h80, 8'h80};

    rst_n  = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; mode3 = 1'b0; a3 = '0; b3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_result", res8, 0);
    check("rst_cout", cout8, 0);
    check("rst_ovf", ovf8, 0);
    check("rst_result3", res3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed WIDTH=8 cases
    run8(1'b1, 8'h5A, 8'h3C);
    check("sub_5A_3C", res8, 8'h1E);
    check("sub_5A_3C_cout", cout8, 0);
    run8(1'b1, 8'h00, 8'h01);
    check("sub_00_01", res8, 8'hFF);
    check("sub_00_01_cout", cout8, 1);
    run8(1'b1, 8'h80, 8'h01);
    run8(1'b0, 8'hFF, 8'h01);
    check("add_FF_01", res8, 8'h00);
    check("add_FF_01_cout", cout8, 1);
    run8(1'b0, 8'h7F, 8'h01);
    check("add_7F_01", res8, 8'h80);

    // Start while busy: second request ignored
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    q8.push_back(model(8, 1'b1, 64'h10, 64'h01));
    @(posedge clk); #1;
    start8 = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) nd++;
      if (i == 2) begin start8 = 1'b1; a8 = 8'hAA; mode8 = 1'b0; end
      if (i == 3) start8 = 1'b0;
    end
    check("busy_cycles", nb, 8);
    check("done_pulses", nd, 1);
    check("ignored_result", res8, 8'h0F);

    // Back-to-back with start held high
    @(negedge clk);
    start8 = 1'b1;
    {mode8, a8, b8} = b2b_ops[0];
    q8.push_back(model(8, b2b_ops[0][16], 64'(b2b_ops[0][15:8]), 64'(b2b_ops[0][7:0])));
    for (int k = 1; k <= 4; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!done8 && cnt < 40);
      check("b2b_gap", cnt, 9);
      if (k < 4) begin
        {mode8, a8, b8} = b2b_ops[k];
        q8.push_back(model(8, b2b_ops[k][16], 64'(b2b_ops[k][15:8]), 64'(b2b_ops[k][7:0])));
      end else begin
        start8 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 0);

    // Reset during RUN at bit 4: operation lost, no done
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h7F; b8 = 8'h7F;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_result", res8, 0);
    check("mid_rst_cout", cout8, 0);
    check("mid_rst_ovf", ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    check("post_rst_idle", nd, 0);

    // Exhaustive WIDTH=3 sweep
    for (int unsigned m = 0; m < 2; m++)
      for (int unsigned x = 0; x < 8; x++)
        for (int unsigned y = 0; y < 8; y++)
          run3(m[0], x[2:0], y[2:0]);
    repeat (3) @(negedge clk);
    check("q3_drained", 64'(q3.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
